bank_timing_tracker: RTL and testbench

//  Parametrised per-bank DRAM timing tracker for the global controller.

---
 rtl/bank_timing_tracker.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_bank_timing_tracker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_timing_tracker.sv
// Per-bank DRAM timing tracker: turns the issued command stream into per-bank ACT/RD/WR/PRE legality.
// Optional inter-bank ACT limits (tRRD, tFAW) are enabled with `define BANK_TIMING_FAW_EN.
module bank_timing_tracker #(
    parameter int NUM_BANKS = 8,
    parameter int BA_BITS   = 3,
    parameter int CNT_W     = 7,
    parameter int T_RCD     = 4,
    parameter int T_RTP     = 3,
    parameter int T_WR_TOT  = 10,
    parameter int T_RP      = 4,
    parameter int T_RAS     = 12,
    parameter int T_RC      = 16,
    parameter int T_RFC     = 40
`ifdef BANK_TIMING_FAW_EN
    ,
    parameter int T_RRD     = 3,
    parameter int T_FAW     = 20
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    input  logic [2:0]             cmd_type,
    input  logic [BA_BITS-1:0]     cmd_bank,
    input  logic                   cmd_ap,
    output logic [NUM_BANKS-1:0]   act_ok,
    output logic [NUM_BANKS-1:0]   rw_ok,
    output logic [NUM_BANKS-1:0]   pre_ok,
    output logic                   ref_ok,
    output logic [NUM_BANKS-1:0]   bank_open,
    output logic [3*NUM_BANKS-1:0] bank_phase,
    output logic                   timing_viol
);

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6,
        CMD_RSVD = 3'd7
    } cmd_t;

    typedef enum logic [2:0] {
        PH_IDLE       = 3'd0,
        PH_WR_TO_PRE  = 3'd1,
        PH_PRE_TO_ACT = 3'd2,
        PH_ACT_TO_RW  = 3'd3,
        PH_RD_TO_PRE  = 3'd4,
        PH_PRE_TO_REF = 3'd5,
        PH_REF_TO_ACT = 3'd6
    } phase_t;

    localparam int CNT_LIM = 2 ** CNT_W;

    if (NUM_BANKS < 2 || (2 ** BA_BITS) < NUM_BANKS) begin : g_bank_chk
        $error("bank_timing_tracker: NUM_BANKS/BA_BITS combination is invalid");
    end

    if (T_RCD < 1 || T_RTP < 1 || T_WR_TOT < 1 || T_RP < 1 || T_RAS < 1 || T_RC < 1 || T_RFC < 1 ||
        T_RCD - 1 >= CNT_LIM || T_RAS - 1 >= CNT_LIM || T_RC - 1 >= CNT_LIM ||
        T_RTP + T_RP - 1 >= CNT_LIM || T_WR_TOT + T_RP - 1 >= CNT_LIM ||
        T_RFC - 1 >= CNT_LIM) begin : g_cnt_chk
        $error("bank_timing_tracker: a timing load value does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] L_RCD      = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] L_RTP      = CNT_W'(T_RTP - 1);
    localparam logic [CNT_W-1:0] L_WR       = CNT_W'(T_WR_TOT - 1);
    localparam logic [CNT_W-1:0] L_RP       = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] L_RAS      = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] L_RC       = CNT_W'(T_RC - 1);
    localparam logic [CNT_W-1:0] L_RFC      = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] L_RP_RD_AP = CNT_W'(T_RTP + T_RP - 1);
    localparam logic [CNT_W-1:0] L_RP_WR_AP = CNT_W'(T_WR_TOT + T_RP - 1);
    localparam logic [BA_BITS:0] NB_LIMIT   = (BA_BITS + 1)'(NUM_BANKS);

    function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] rcd_q [NUM_BANKS];
    logic [CNT_W-1:0] pre_q [NUM_BANKS];
    logic [CNT_W-1:0] rp_q  [NUM_BANKS];
    logic [CNT_W-1:0] ras_q [NUM_BANKS];
    logic [CNT_W-1:0] rc_q  [NUM_BANKS];
    logic [CNT_W-1:0] rcd_d [NUM_BANKS];
    logic [CNT_W-1:0] pre_d [NUM_BANKS];
    logic [CNT_W-1:0] rp_d  [NUM_BANKS];
    logic [CNT_W-1:0] ras_d [NUM_BANKS];
    logic [CNT_W-1:0] rc_d  [NUM_BANKS];
    phase_t           phase_q [NUM_BANKS];
    phase_t           phase_d [NUM_BANKS];
    logic [NUM_BANKS-1:0] open_q, open_d;
    logic [NUM_BANKS-1:0] ph_load;
    logic [NUM_BANKS-1:0] sel;
    logic [NUM_BANKS-1:0] act_base;
    logic                 all_settled;
    logic                 bank_valid;
    logic                 act_gate;
    logic                 viol_q, viol_d;
    logic [CNT_W-1:0]     pre_rd;
    cmd_t                 cmd;

    assign cmd        = cmd_t'(cmd_type);
    assign bank_valid = ({1'b0, cmd_bank} < NB_LIMIT);

    always_comb begin
        sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            sel[b] = (cmd_bank == BA_BITS'(b));
        end
    end

    // Legality is derived purely from registered state so the scheduler sees stable flags.
    always_comb begin
        act_base    = '0;
        rw_ok       = '0;
        pre_ok      = '0;
        bank_phase  = '0;
        all_settled = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            act_base[b] = !open_q[b] && (rp_q[b] == '0) && (rc_q[b] == '0);
            rw_ok[b]    = open_q[b] && (rcd_q[b] == '0);
            pre_ok[b]   = open_q[b] && (pre_q[b] == '0) && (ras_q[b] == '0);
            bank_phase[3*b +: 3] = phase_q[b];
            if (rp_q[b] != '0 || rc_q[b] != '0) begin
                all_settled = 1'b0;
            end
        end
    end

    assign act_ok      = act_base & {NUM_BANKS{act_gate}};
    assign ref_ok      = !(|open_q) && all_settled;
    assign bank_open   = open_q;
    assign timing_viol = viol_q;

    always_comb begin
        viol_d = 1'b0;
        if (cmd_valid) begin
            case (cmd)
                CMD_ACT:        viol_d = !bank_valid || !(|(act_ok & sel));
                CMD_RD, CMD_WR: viol_d = !bank_valid || !(|(rw_ok & sel));
                // PRE to a closed bank is a harmless no-op, so only an open bank can violate.
                CMD_PRE:        viol_d = !bank_valid || ((|(open_q & sel)) && !(|(pre_ok & sel)));
                CMD_REF:        viol_d = !ref_ok;
                default:        viol_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        ph_load = '0;
        pre_rd  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rcd_d[b]   = dec(rcd_q[b]);
            pre_d[b]   = dec(pre_q[b]);
            rp_d[b]    = dec(rp_q[b]);
            ras_d[b]   = dec(ras_q[b]);
            rc_d[b]    = dec(rc_q[b]);
            open_d[b]  = open_q[b];
            phase_d[b] = phase_q[b];

            if (cmd_valid) begin
                case (cmd)
                    CMD_ACT: begin
                        if (sel[b]) begin
                            rcd_d[b]   = L_RCD;
                            ras_d[b]   = L_RAS;
                            rc_d[b]    = L_RC;
                            open_d[b]  = 1'b1;
                            phase_d[b] = PH_ACT_TO_RW;
                            ph_load[b] = 1'b1;
                        end
                    end
                    CMD_RD: begin
                        if (sel[b]) begin
                            pre_rd     = dec(pre_q[b]);
                            pre_d[b]   = (pre_rd > L_RTP) ? pre_rd : L_RTP;
                            phase_d[b] = PH_RD_TO_PRE;
                            ph_load[b] = 1'b1;
                            if (cmd_ap) begin
                                rp_d[b]    = L_RP_RD_AP;
                                open_d[b]  = 1'b0;
                                phase_d[b] = PH_PRE_TO_ACT;
                            end
                        end
                    end
                    CMD_WR: begin
                        if (sel[b]) begin
                            pre_d[b]   = L_WR;
                            phase_d[b] = PH_WR_TO_PRE;
                            ph_load[b] = 1'b1;
                            if (cmd_ap) begin
                                rp_d[b]    = L_RP_WR_AP;
                                open_d[b]  = 1'b0;
                                phase_d[b] = PH_PRE_TO_ACT;
                            end
                        end
                    end
                    CMD_PRE: begin
                        if (sel[b] && open_q[b]) begin
                            rp_d[b]    = L_RP;
                            open_d[b]  = 1'b0;
                            phase_d[b] = PH_PRE_TO_ACT;
                            ph_load[b] = 1'b1;
                        end
                    end
                    CMD_PREA: begin
                        if (open_q[b]) begin
                            rp_d[b]    = L_RP;
                            open_d[b]  = 1'b0;
                            phase_d[b] = PH_PRE_TO_REF;
                            ph_load[b] = 1'b1;
                        end
                    end
                    CMD_REF: begin
                        rp_d[b]    = L_RFC;
                        phase_d[b] = PH_REF_TO_ACT;
                        ph_load[b] = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            // A settled closed bank drops back to idle, but a freshly loaded event stays visible.
            if (!ph_load[b] && !open_d[b] && (rp_d[b] == '0)) begin
                phase_d[b] = PH_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rcd_q[b]   <= '0;
                pre_q[b]   <= '0;
                rp_q[b]    <= '0;
                ras_q[b]   <= '0;
                rc_q[b]    <= '0;
                phase_q[b] <= PH_IDLE;
            end
            open_q <= '0;
            viol_q <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rcd_q[b]   <= rcd_d[b];
                pre_q[b]   <= pre_d[b];
                rp_q[b]    <= rp_d[b];
                ras_q[b]   <= ras_d[b];
                rc_q[b]    <= rc_d[b];
                phase_q[b] <= phase_d[b];
            end
            open_q <= open_d;
            viol_q <= viol_d;
        end
    end

`ifdef BANK_TIMING_FAW_EN
    if (T_RRD < 1 || T_FAW < 1 || T_RRD - 1 >= CNT_LIM || T_FAW - 1 >= CNT_LIM) begin : g_faw_chk
        $error("bank_timing_tracker: T_RRD/T_FAW load value does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] L_RRD = CNT_W'(T_RRD - 1);
    localparam logic [CNT_W-1:0] L_FAW = CNT_W'(T_FAW - 1);

    logic [CNT_W-1:0] rrd_q, rrd_d;
    logic [CNT_W-1:0] faw_q [4];
    logic [CNT_W-1:0] faw_d [4];
    logic [1:0]       faw_ptr_q, faw_ptr_d;
    logic             act_fire;

    // Each window slot ages out T_FAW cycles after its ACT; four live slots block further ACTs.
    assign act_fire = cmd_valid && (cmd == CMD_ACT) && bank_valid;
    assign act_gate = (rrd_q == '0) &&
                      !((faw_q[0] != '0) && (faw_q[1] != '0) && (faw_q[2] != '0) && (faw_q[3] != '0));

    always_comb begin
        rrd_d     = dec(rrd_q);
        faw_ptr_d = faw_ptr_q;
        for (int i = 0; i < 4; i++) begin
            faw_d[i] = dec(faw_q[i]);
        end
        if (act_fire) begin
            rrd_d            = L_RRD;
            faw_d[faw_ptr_q] = L_FAW;
            faw_ptr_d        = faw_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_q     <= '0;
            faw_ptr_q <= '0;
            for (int i = 0; i < 4; i++) begin
                faw_q[i] <= '0;
            end
        end else begin
            rrd_q     <= rrd_d;
            faw_ptr_q <= faw_ptr_d;
            for (int i = 0; i < 4; i++) begin
                faw_q[i] <= faw_d[i];
            end
        end
    end
`else
    assign act_gate = 1'b1;
`endif

endmodule

// File: tb/tb_bank_timing_tracker.sv
// Self-checking bench for bank_timing_tracker: directed vector table plus multi-cycle sequences.
module tb_bank_timing_tracker;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] ACT  = 3'd1;
    localparam logic [2:0] RD   = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] PRE  = 3'd4;
    localparam logic [2:0] PREA = 3'd5;
    localparam logic [2:0] REF  = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [2:0]  cmd_bank;
    logic        cmd_ap;
    logic [7:0]  act_ok;
    logic [7:0]  rw_ok;
    logic [7:0]  pre_ok;
    logic        ref_ok;
    logic [7:0]  bank_open;
    logic [23:0] bank_phase;
    logic        timing_viol;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bank_timing_tracker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_type    (cmd_type),
        .cmd_bank    (cmd_bank),
        .cmd_ap      (cmd_ap),
        .act_ok      (act_ok),
        .rw_ok       (rw_ok),
        .pre_ok      (pre_ok),
        .ref_ok      (ref_ok),
        .bank_open   (bank_open),
        .bank_phase  (bank_phase),
        .timing_viol (timing_viol)
    );

    typedef struct {
        bit          rst_before;
        logic [2:0]  typ;
        logic [2:0]  bank;
        logic        ap;
        logic [7:0]  e_act;
        logic [7:0]  e_rw;
        logic [7:0]  e_pre;
        logic        e_ref;
        logic [7:0]  e_open;
        logic [23:0] e_phase;
        logic        e_viol;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input bit r, input logic [2:0] t, input logic [2:0] b, input logic ap,
                                input logic [7:0] ea, input logic [7:0] er, input logic [7:0] ep,
                                input logic ef, input logic [7:0] eo, input logic [23:0] eph,
                                input logic ev);
        vec_t v;
        v.rst_before = r;  v.typ = t;   v.bank = b;   v.ap = ap;
        v.e_act = ea;      v.e_rw = er; v.e_pre = ep; v.e_ref = ef;
        v.e_open = eo;     v.e_phase = eph;           v.e_viol = ev;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic issue(input logic [2:0] t, input logic [2:0] b, input logic ap);
        cmd_valid = (t != NOP);
        cmd_type  = t;
        cmd_bank  = b;
        cmd_ap    = ap;
        step();
        cmd_valid = 1'b0;
        cmd_type  = NOP;
        cmd_bank  = '0;
        cmd_ap    = 1'b0;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        cmd_type  = NOP;
        cmd_bank  = '0;
        cmd_ap    = 1'b0;
        rst_n     = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, " act_ok"},      32'(act_ok),      32'h0000_00FF);
        check_val({tag, " rw_ok"},       32'(rw_ok),       32'h0);
        check_val({tag, " pre_ok"},      32'(pre_ok),      32'h0);
        check_val({tag, " ref_ok"},      32'(ref_ok),      32'h1);
        check_val({tag, " bank_open"},   32'(bank_open),   32'h0);
        check_val({tag, " bank_phase"},  32'(bank_phase),  32'h0);
        check_val({tag, " timing_viol"}, 32'(timing_viol), 32'h0);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.rst_before) do_reset();
        issue(v.typ, v.bank, v.ap);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        check_val($sformatf("vec%0d act_ok", idx),      32'(act_ok),      32'(v.e_act));
        check_val($sformatf("vec%0d rw_ok", idx),       32'(rw_ok),       32'(v.e_rw));
        check_val($sformatf("vec%0d pre_ok", idx),      32'(pre_ok),      32'(v.e_pre));
        check_val($sformatf("vec%0d ref_ok", idx),      32'(ref_ok),      32'(v.e_ref));
        check_val($sformatf("vec%0d bank_open", idx),   32'(bank_open),   32'(v.e_open));
        check_val($sformatf("vec%0d bank_phase", idx),  32'(bank_phase),  32'(v.e_phase));
        check_val($sformatf("vec%0d timing_viol", idx), 32'(timing_viol), 32'(v.e_viol));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // ACT b2: rw_ok[2] rises after tRCD, bank 2 stays blocked for ACT
        vecs[0]  = mk(1, ACT, 3'd2, 0, 8'hFB, 8'h00, 8'h00, 0, 8'h04, 24'h0000C0, 0);
        vecs[1]  = mk(0, NOP, 3'd0, 0, 8'hFB, 8'h00, 8'h00, 0, 8'h04, 24'h0000C0, 0);
        vecs[2]  = mk(0, NOP, 3'd0, 0, 8'hFB, 8'h00, 8'h00, 0, 8'h04, 24'h0000C0, 0);
        vecs[3]  = mk(0, NOP, 3'd0, 0, 8'hFB, 8'h04, 8'h00, 0, 8'h04, 24'h0000C0, 0);
        // ACT b3, early RD (tRCD) and early re-ACT (open/tRC) both violate
        vecs[4]  = mk(1, ACT, 3'd3, 0, 8'hF7, 8'h00, 8'h00, 0, 8'h08, 24'h000600, 0);
        vecs[5]  = mk(0, NOP, 3'd0, 0, 8'hF7, 8'h00, 8'h00, 0, 8'h08, 24'h000600, 0);
        vecs[6]  = mk(0, RD,  3'd3, 0, 8'hF7, 8'h00, 8'h00, 0, 8'h08, 24'h000800, 1);
        vecs[7]  = mk(0, NOP, 3'd0, 0, 8'hF7, 8'h08, 8'h00, 0, 8'h08, 24'h000800, 0);
        vecs[8]  = mk(0, NOP, 3'd0, 0, 8'hF7, 8'h08, 8'h00, 0, 8'h08, 24'h000800, 0);
        vecs[9]  = mk(0, ACT, 3'd3, 0, 8'hF7, 8'h00, 8'h00, 0, 8'h08, 24'h000600, 1);
        vecs[10] = mk(0, NOP, 3'd0, 0, 8'hF7, 8'h00, 8'h00, 0, 8'h08, 24'h000600, 0);
        // PRE to closed bank is a no-op, RD to closed bank violates, REF legal then illegal
        vecs[11] = mk(1, PRE, 3'd6, 0, 8'hFF, 8'h00, 8'h00, 1, 8'h00, 24'h000000, 0);
        vecs[12] = mk(0, RD,  3'd6, 0, 8'hFF, 8'h00, 8'h00, 1, 8'h00, 24'h100000, 1);
        vecs[13] = mk(0, NOP, 3'd0, 0, 8'hFF, 8'h00, 8'h00, 1, 8'h00, 24'h000000, 0);
        vecs[14] = mk(0, REF, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 24'hDB6DB6, 0);
        vecs[15] = mk(0, REF, 3'd0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 24'hDB6DB6, 1);

        cmd_valid = 1'b0;
        cmd_type  = NOP;
        cmd_bank  = '0;
        cmd_ap    = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_reset_values("async_reset");
        do_reset();
        check_reset_values("reset");

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // ACT b0, RD at t4: PRE blocked by tRAS until t12, then ACT legal at t16
        do_reset();
        issue(ACT, 3'd0, 0);
        idle(3);
        check_val("s2 rw_ok0 t4", 32'(rw_ok[0]), 32'h1);
        issue(RD, 3'd0, 0);
        check_val("s2 pre_ok0 t5", 32'(pre_ok[0]), 32'h0);
        idle(6);
        check_val("s2 pre_ok0 t11", 32'(pre_ok[0]), 32'h0);
        idle(1);
        check_val("s2 pre_ok0 t12", 32'(pre_ok[0]), 32'h1);
        issue(PRE, 3'd0, 0);
        check_val("s2 viol t13", 32'(timing_viol), 32'h0);
        check_val("s2 phase0 t13", 32'(bank_phase[2:0]), 32'h2);
        idle(2);
        check_val("s2 act_ok0 t15", 32'(act_ok[0]), 32'h0);
        idle(1);
        check_val("s2 act_ok0 t16", 32'(act_ok[0]), 32'h1);
        check_val("s2 phase0 t16", 32'(bank_phase[2:0]), 32'h0);

        // ACT b1, WR with auto-precharge at t4: bank closes at t5, ACT legal at t18
        do_reset();
        issue(ACT, 3'd1, 0);
        idle(3);
        check_val("s3 rw_ok1 t4", 32'(rw_ok[1]), 32'h1);
        issue(WR, 3'd1, 1);
        check_val("s3 open1 t5", 32'(bank_open[1]), 32'h0);
        check_val("s3 phase1 t5", 32'(bank_phase[5:3]), 32'h2);
        check_val("s3 viol t5", 32'(timing_viol), 32'h0);
        idle(12);
        check_val("s3 act_ok1 t17", 32'(act_ok[1]), 32'h0);
        idle(1);
        check_val("s3 act_ok1 t18", 32'(act_ok[1]), 32'h1);

        // Banks 0 and 5 open, PREA then REF: tRP then tRFC lockout
        do_reset();
        issue(ACT, 3'd0, 0);
        issue(ACT, 3'd5, 0);
        idle(20);
        check_val("s5 open pre-PREA", 32'(bank_open), 32'h21);
        issue(PREA, 3'd0, 0);
        check_val("s5 phase t1", 32'(bank_phase), 32'h028005);
        check_val("s5 open t1", 32'(bank_open), 32'h0);
        check_val("s5 ref_ok t1", 32'(ref_ok), 32'h0);
        idle(2);
        check_val("s5 ref_ok t3", 32'(ref_ok), 32'h0);
        idle(1);
        check_val("s5 ref_ok t4", 32'(ref_ok), 32'h1);
        check_val("s5 act_ok t4", 32'(act_ok), 32'hFF);
        issue(REF, 3'd0, 0);
        check_val("s5 phase t5", 32'(bank_phase), 32'hDB6DB6);
        check_val("s5 act_ok t5", 32'(act_ok), 32'h00);
        check_val("s5 viol t5", 32'(timing_viol), 32'h0);
        idle(38);
        check_val("s5 act_ok t43", 32'(act_ok), 32'h00);
        idle(1);
        check_val("s5 act_ok t44", 32'(act_ok), 32'hFF);
        check_val("s5 phase t44", 32'(bank_phase), 32'h0);
        check_val("s5 ref_ok t44", 32'(ref_ok), 32'h1);

        // Reset asserted mid-operation while a violation pulse is showing
        do_reset();
        issue(ACT, 3'd7, 0);
        issue(RD, 3'd7, 0);
        check_val("midrst viol before", 32'(timing_viol), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        step();
        rst_n = 1'b1;
        idle(1);

`ifdef BANK_TIMING_FAW_EN
        // Four ACTs spaced by tRRD fill the tFAW window; a fifth bank waits until t20
        do_reset();
        issue(ACT, 3'd0, 0);
        idle(2);
        issue(ACT, 3'd1, 0);
        idle(2);
        issue(ACT, 3'd2, 0);
        idle(2);
        issue(ACT, 3'd3, 0);
        check_val("faw viol t10", 32'(timing_viol), 32'h0);
        check_val("faw act_ok4 t10", 32'(act_ok[4]), 32'h0);
        idle(9);
        check_val("faw act_ok4 t19", 32'(act_ok[4]), 32'h0);
        idle(1);
        check_val("faw act_ok4 t20", 32'(act_ok[4]), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_values("faw_rst");
        step();
        rst_n = 1'b1;
        idle(1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
